// File: rtl/decoder_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg
//
// Shared definitions for the 2-to-4 decoder block.
//   SEL_W         : width of the select code
//   N_OUT         : number of decoded lines
//   sel_t         : select code type
//   onehot_t      : decoded one-hot (or all-zero) vector type
//   onehot_decode : combinational decode used by the RTL and by checking models
// ----------------------------------------------------------------------------
package decoder_pkg;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned N_OUT = 4;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_OUT-1:0] onehot_t;

    // Bitwise AND keeps X/Z on sel or en visible on the result instead of
    // silently masking it to zero.
    function automatic onehot_t onehot_decode(input sel_t sel, input logic en);
        onehot_t res;
        res = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            res[k] = en & (sel == SEL_W'(k));
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_2to4_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter used for per-line hit statistics.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears the count
//   clr   : synchronous clear; wins over a coincident increment
//   inc   : increment request for this cycle
//   count : current count, sticks at all-ones once reached
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MaxVal = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MaxVal)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/decoder_2to4.sv
// ----------------------------------------------------------------------------
// decoder_2to4
//
// 2-to-4 one-hot decoder with enable, a registered copy of the decode and
// per-line saturating hit counters.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset (out_q and counters only)
//   in      : select code
//   enable  : decode enable, active high
//   out     : combinational one-hot decode (all-zero when disabled)
//   out_q   : out delayed by one clock
//   clr_cnt : synchronous clear of all hit counters
//   hit_cnt : packed counters, line k at [k*CNT_W +: CNT_W]
// ----------------------------------------------------------------------------
module decoder_2to4
    import decoder_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         in,
    input  logic                     enable,
    output logic [N_OUT-1:0]         out,
    output logic [N_OUT-1:0]         out_q,
    input  logic                     clr_cnt,
    output logic [N_OUT*CNT_W-1:0]   hit_cnt
);

    onehot_t dec;
    onehot_t dec_q;
    onehot_t dec_d;

    assign dec = onehot_decode(in, enable);
    assign out = dec;

    always_comb begin
        dec_d = dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign out_q = dec_q;

    // Since dec is one-hot or zero, at most one counter advances per cycle.
    for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr_cnt),
            .inc   (dec[k]),
            .count (hit_cnt[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_decoder_2to4.sv
module tb_decoder_2to4;

    logic        clk;
    logic        rst;
    logic [1:0]  in;
    logic        enable;
    logic        clr_cnt;
    logic [3:0]  out_a, out_q_a;
    logic [3:0]  out_b, out_q_b;
    logic [63:0] hit_a;
    logic [7:0]  hit_b;

    // Wide counters and a 2-bit instance for saturation, same stimulus.
    decoder_2to4 #(.CNT_W(16)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .enable  (enable),
        .out     (out_a),
        .out_q   (out_q_a),
        .clr_cnt (clr_cnt),
        .hit_cnt (hit_a)
    );

    decoder_2to4 #(.CNT_W(2)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .enable  (enable),
        .out     (out_b),
        .out_q   (out_q_b),
        .clr_cnt (clr_cnt),
        .hit_cnt (hit_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  oq;
        logic [63:0] h16;
        logic [7:0]  h2;
    } exp_t;

    typedef struct {
        logic [1:0] sel;
        logic       en;
        logic [3:0] exp_out;
    } vec_t;

    exp_t sb[$];
    int   m16[4];
    int   m2[4];
    int   n_pass;
    int   n_total;

    function automatic logic [3:0] ref_dec(input logic [1:0] s, input logic e);
        logic [3:0] one;
        one = 4'b0001 << s;
        return e ? one : 4'b0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: drive at negedge, check the combinational decode, update the
    // model, push expectations, then check registered state after the edge.
    task automatic step(input logic [1:0] s, input logic e, input logic r, input logic c,
                        input logic [3:0] exp_out);
        exp_t x;
        exp_t got;
        @(negedge clk);
        in = s;
        enable = e;
        rst = r;
        clr_cnt = c;
        #1;
        check("out_a", 64'(out_a), 64'(exp_out));
        check("out_b", 64'(out_b), 64'(exp_out));
        if (r || c) begin
            for (int k = 0; k < 4; k++) begin
                m16[k] = 0;
                m2[k]  = 0;
            end
        end else if (e) begin
            if (m16[s] < 65535) m16[s]++;
            if (m2[s] < 3) m2[s]++;
        end
        x.oq = r ? 4'b0000 : ref_dec(s, e);
        for (int k = 0; k < 4; k++) begin
            x.h16[k*16 +: 16] = 16'(m16[k]);
            x.h2[k*2 +: 2]    = 2'(m2[k]);
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            got = sb.pop_front();
            check("out_q_a", 64'(out_q_a), 64'(got.oq));
            check("out_q_b", 64'(out_q_b), 64'(got.oq));
            check("hit_a", hit_a, got.h16);
            check("hit_b", 64'(hit_b), 64'(got.h2));
        end
    endtask

    vec_t vecs[6];

    initial begin
        logic [1:0] rs;
        logic       re;
        n_pass  = 0;
        n_total = 0;
        for (int k = 0; k < 4; k++) begin
            m16[k] = 0;
            m2[k]  = 0;
        end
        rst = 1'b1;
        in = 2'b00;
        enable = 1'b0;
        clr_cnt = 1'b0;

        vecs[0] = '{sel: 2'b00, en: 1'b1, exp_out: 4'b0001};
        vecs[1] = '{sel: 2'b01, en: 1'b1, exp_out: 4'b0010};
        vecs[2] = '{sel: 2'b10, en: 1'b1, exp_out: 4'b0100};
        vecs[3] = '{sel: 2'b11, en: 1'b1, exp_out: 4'b1000};
        vecs[4] = '{sel: 2'b00, en: 1'b0, exp_out: 4'b0000};
        vecs[5] = '{sel: 2'b11, en: 1'b0, exp_out: 4'b0000};

        // Reset state.
        step(2'b00, 1'b0, 1'b1, 1'b0, 4'b0000);
        step(2'b00, 1'b0, 1'b1, 1'b0, 4'b0000);
        check("reset_out_q", 64'(out_q_a), 64'd0);
        check("reset_hit", hit_a, 64'd0);

        // Table-driven decode.
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].sel, vecs[i].en, 1'b0, 1'b0, vecs[i].exp_out);
        end
        check("table_hits", hit_a, {16'd1, 16'd1, 16'd1, 16'd1});

        // Reset mid-operation, then count three hits on line 2.
        step(2'b01, 1'b1, 1'b1, 1'b0, 4'b0010);
        step(2'b11, 1'b1, 1'b1, 1'b0, 4'b1000);
        check("midrst_hit", hit_a, 64'd0);
        for (int i = 0; i < 3; i++) step(2'b10, 1'b1, 1'b0, 1'b0, 4'b0100);
        check("line2_hits", hit_a, {16'd0, 16'd3, 16'd0, 16'd0});
        check("line2_out_q", 64'(out_q_a), 64'h4);

        // Saturation on the 2-bit instance.
        for (int i = 0; i < 6; i++) step(2'b01, 1'b1, 1'b0, 1'b0, 4'b0010);
        check("sat_line1", 64'(hit_b[2 +: 2]), 64'd3);
        check("sat_line0", 64'(hit_b[0 +: 2]), 64'd0);
        check("wide_line1", 64'(hit_a[16 +: 16]), 64'd6);

        // Clear wins over a coincident increment.
        step(2'b11, 1'b1, 1'b0, 1'b1, 4'b1000);
        check("clr_hit_a", hit_a, 64'd0);
        check("clr_hit_b", 64'(hit_b), 64'd0);
        check("clr_out_q", 64'(out_q_a), 64'h8);

        // Random stream.
        for (int i = 0; i < 1000; i++) begin
            rs = 2'($urandom_range(0, 3));
            re = 1'($urandom_range(0, 1));
            step(rs, re, 1'b0, 1'b0, ref_dec(rs, re));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/decoder_2to4.md
Name: decoder_2to4

Overview:
- 2-to-4 one-hot decoder with active-high enable, used as a select/strobe generator in control paths.
- Provides a combinational decoded output and a registered copy of it.
- Keeps per-line saturating hit counters for debug and coverage readout.
- Single clock domain. Reset affects only the registered outputs and the counters.

Parameters:
- CNT_W, default 16, width of each per-line hit counter (legal range 1..32).

Ports:
- clk      input   1          rising-edge clock
- rst      input   1          synchronous, active-high reset
- in       input   2          select code
- enable   input   1          decode enable, active high
- out      output  4          combinational one-hot decode
- out_q    output  4          registered copy of out
- clr_cnt  input   1          synchronous clear of all hit counters, active high
- hit_cnt  output  4*CNT_W    packed counters; line k occupies bits [k*CNT_W +: CNT_W]

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Combinational path:
  - out[k] = enable && (in == k), for k = 0..3.
  - enable=0 forces out = 4'b0000 regardless of in.
  - Zero latency; no clock dependence; valid whenever inputs are stable.
  - in or enable containing X/Z drives out to X. No masking is required.
- Registered path:
  - out_q <= out on every rising clk edge.
  - 1-cycle latency from in/enable to out_q.
  - rst=1 at a clock edge: out_q <= 4'b0000. rst has priority over everything else.
- Hit counters:
  - At each clock edge with rst=0 and clr_cnt=0: for each k with out[k]=1, hit_cnt[k] increments by 1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - At most one counter increments per cycle, because out is one-hot or zero.
  - clr_cnt=1 at an edge: all counters go to 0. Any increment in that same cycle is discarded.
  - rst=1 clears all counters, same as clr_cnt. rst asserted in the middle of operation clears counters and out_q on that edge only. Counting resumes on the first edge with rst=0.
- Reset values: out_q = 0, every hit_cnt field = 0. out has no reset value (purely combinational).
- Invariant: out and out_q are always one-hot or all-zero.

Decomposition:
- Shared package decoder_pkg:
  - localparam SEL_W = 2 and N_OUT = 4.
  - A function onehot_decode(sel, en) that returns N_OUT bits. It is reused by the combinational path and by the verification model.
- One sub-module sat_counter (parameter CNT_W; ports clk, rst, clr, inc, count), instantiated 4 times via generate.
- The top module holds the decode logic, the out_q register and the counter array.

Test Plan:
- enable=1, in = 00/01/10/11, each held 10 ns -> out = 0001/0010/0100/1000 immediately (no clock edge needed). out_q shows the same values one clk edge later.
- enable=0 with in=00 and with in=11 -> out = 0000. out_q = 0000 after the next edge. No counter changes.
- rst=1 for 2 cycles after arbitrary activity -> out_q = 0000, all hit_cnt = 0. Release rst, enable=1, in=10 for 3 cycles -> hit_cnt[2] = 3, others 0, out_q = 0100.
- CNT_W=2, enable=1, in=01 held for 6 cycles -> hit_cnt[1] reaches 3 and stays at 3 (saturated). Other counters stay 0.
- clr_cnt=1 in the same cycle as enable=1, in=11 -> every counter reads 0 after the edge (clear wins). out_q = 1000 after the edge.
- Random in/enable stream for 1000 cycles -> out matches onehot_decode every cycle, and out_q matches the previous cycle's out. Each hit_cnt[k] equals the number of edges where enable=1 and in=k, until saturation.
